// File: rtl/img3d_pkg.sv
// img3d_pkg: shared types and widths for the 3D-imaging cache reader.
package img3d_pkg;
  localparam int IMG3D_DATA_W = 32;
  localparam int IMG3D_LEN_W  = 16;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;
endpackage

// File: rtl/img3d_rd_buf2.sv
// img3d_rd_buf2: 2-entry FIFO-ordered output buffer with occupancy and synchronous clear.
module img3d_rd_buf2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   occ_o
);
  logic [W-1:0] head_q, tail_q;
  logic [1:0] occ_q;
  logic head_we, tail_we;
  // head refills from tail when full, or straight from din when the pushed word lands at the front
  assign head_we = pop_i ? (occ_q == 2'd2 || push_i) : (push_i && occ_q == 2'd0);
  assign tail_we = push_i && (pop_i ? occ_q == 2'd2 : occ_q == 2'd1);
  assign dout_o  = head_q;
  assign occ_o   = occ_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (head_we) head_q <= (pop_i && occ_q == 2'd2) ? tail_q : din_i;
      if (tail_we) tail_q <= din_i;
    end
    occ_q <= (rst || clr_i) ? 2'd0 : occ_q + {1'b0, push_i} - {1'b0, pop_i};
  end
endmodule

// File: rtl/img3d_cache_reader.sv
// img3d_cache_reader: drains the DDR cache FIFO into a framed AXI4-Stream, one frame at a time.
// Define IMG3D_CACHE_RD_STAT_EN to build the saturating starvation counter behind stat_underrun.
module img3d_cache_reader
  import img3d_pkg::*;
#(
  parameter int DATA_W = IMG3D_DATA_W,
  parameter int LEN_W  = IMG3D_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [7:0]        frame_num,
  input  logic [DATA_W-1:0] fifo_rddata,
  output logic              fifo_rden,
  input  logic              fifo_empty,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [15:0]       stat_underrun
);
  localparam int RW = LEN_W + 8;
  state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, word_cnt_q, word_cnt_d;
  logic [7:0] num_q, num_d, frm_cnt_q, frm_cnt_d;
  logic [RW-1:0] rd_left_q, rd_left_d;
  logic inflight_q, pop, push, clr, go, zero_cfg, last_frame;
  logic [1:0] occ;
  logic [2:0] level;
  assign zero_cfg      = frame_len == '0 || frame_num == '0;
  assign go            = state_q == IDLE && start && !abort && !zero_cfg;
  assign cfg_err       = state_q == IDLE && start && zero_cfg;
  assign busy          = state_q != IDLE;
  assign m_axis_tvalid = occ != 2'd0;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tuser  = m_axis_tvalid && word_cnt_q == '0;
  assign m_axis_tlast  = m_axis_tvalid && word_cnt_q == len_q - LEN_W'(1);
  assign last_frame    = frm_cnt_q == num_q - 8'd1;
  assign done          = pop && m_axis_tlast && last_frame;
  // words already owed to the buffer; a read may only issue if its word will have a slot
  assign level         = 3'(occ) + 3'(inflight_q);
  assign fifo_rden     = state_q == STREAM && !abort && !fifo_empty && rd_left_q != '0 && level < 3'd2 + 3'(pop);
  assign clr           = state_q == STREAM && abort;
  assign push          = inflight_q && state_q == STREAM;
  img3d_rd_buf2 #(.W(DATA_W)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (fifo_rddata),
    .dout_o (m_axis_tdata),
    .occ_o  (occ)
  );
  always_comb begin
    state_d    = go ? STREAM
               : (state_q == STREAM && done) ? IDLE
               : (state_q == STREAM && abort) ? FLUSH
               : (state_q == FLUSH && !inflight_q) ? IDLE : state_q;
    len_d      = go ? frame_len : len_q;
    num_d      = go ? frame_num : num_q;
    rd_left_d  = go ? RW'(frame_len) * RW'(frame_num) : rd_left_q - RW'(fifo_rden);
    word_cnt_d = (go || (pop && m_axis_tlast)) ? '0 : word_cnt_q + LEN_W'(pop);
    frm_cnt_d  = go ? '0 : frm_cnt_q + 8'(pop && m_axis_tlast);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      num_q      <= '0;
      rd_left_q  <= '0;
      word_cnt_q <= '0;
      frm_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      num_q      <= num_d;
      rd_left_q  <= rd_left_d;
      word_cnt_q <= word_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      inflight_q <= fifo_rden;
    end
  end
`ifdef IMG3D_CACHE_RD_STAT_EN
  logic [15:0] stat_q, stat_d;
  assign stat_d = (state_q == STREAM && occ == 2'd0 && !inflight_q && fifo_empty && rd_left_q != '0 && stat_q != 16'hFFFF)
                ? stat_q + 16'd1 : stat_q;
  always_ff @(posedge clk) begin
    stat_q <= (rst || go) ? '0 : stat_d;
  end
  assign stat_underrun = stat_q;
`else
  assign stat_underrun = '0;
`endif
endmodule

// File: tb/tb_img3d_cache_reader.sv
// tb_img3d_cache_reader: reference-model bench for the cache reader with a behavioural cache FIFO.
module tb_img3d_cache_reader;
  localparam int DW = 32;
  localparam int LW = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, fifo_empty = 1'b1, tready = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic [7:0] frame_num = '0;
  logic [DW-1:0] fifo_rddata = '0, tdata;
  logic fifo_rden, tvalid, tlast, tuser, busy, done, cfg_err;
  logic [15:0] stat_underrun;

  img3d_cache_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_len(frame_len), .frame_num(frame_num),
    .fifo_rddata(fifo_rddata), .fifo_rden(fifo_rden), .fifo_empty(fifo_empty),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser), .busy(busy), .done(done),
    .cfg_err(cfg_err), .stat_underrun(stat_underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  logic [DW-1:0] src[$], exp_q[$], log_d[$], pend_d = '0, rd_word;
  bit log_u[$], log_l[$];
  int log_c[$];
  bit starve = 1'b0, pend = 1'b0, rst_prev = 1'b0;
  int m_st = 0, m_len = 1, total = 0, issued = 0, popped = 0, m_stat = 0, occ_m;
  bit m_infl = 1'b0, e_valid, e_pop, e_rden, e_done;
  int rden_cnt, done_cnt, done_idx, cfg_cnt, first_v, sc, ac, ic, exp_stat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // cache FIFO: data appears the cycle after the read strobe; empty reflects reads through the last edge
  always @(posedge clk) begin
    #2;
    if (pend) fifo_rddata = pend_d;
    fifo_empty = starve || src.size() == 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (rst_prev) begin
        chk("rst_rden", fifo_rden, 0); chk("rst_tvalid", tvalid, 0); chk("rst_tlast", tlast, 0);
        chk("rst_tuser", tuser, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0); chk("rst_tdata", tdata, 0); chk("rst_stat", stat_underrun, 0);
      end
      m_st = 0; m_stat = 0; m_infl = 0; exp_q.delete(); src.delete(); pend = 0; rst_prev = 1;
    end else begin
      rst_prev = 0;
      occ_m   = issued - popped - int'(m_infl);
      e_valid = m_st == 1 && occ_m > 0;
      e_pop   = e_valid && tready;
      e_rden  = m_st == 1 && !abort && !fifo_empty && issued < total && (issued - popped - int'(e_pop)) < 2;
      e_done  = e_pop && popped == total - 1;
      chk("tvalid", tvalid, e_valid);
      chk("fifo_rden", fifo_rden, e_rden);
      chk("busy", busy, m_st != 0);
      chk("done", done, e_done);
      chk("cfg_err", cfg_err, m_st == 0 && start && (frame_len == 0 || frame_num == 0));
`ifdef IMG3D_CACHE_RD_STAT_EN
      exp_stat = m_stat;
`else
      exp_stat = 0;
`endif
      chk("stat_underrun", stat_underrun, exp_stat);
      if (e_valid) begin
        chk("tdata", tdata, exp_q.size() != 0 ? exp_q[0] : 'x);
        chk("tuser", tuser, popped % m_len == 0);
        chk("tlast", tlast, popped % m_len == m_len - 1);
      end
      if (tvalid && tready) begin
        log_d.push_back(tdata); log_u.push_back(tuser); log_l.push_back(tlast); log_c.push_back(cyc);
        if (first_v < 0) first_v = cyc;
      end
      if (done) begin done_cnt++; done_idx = log_d.size() - 1; end
      if (fifo_rden) rden_cnt++;
      if (cfg_err) cfg_cnt++;
      if (m_st == 1 && issued == popped && fifo_empty && issued < total && m_stat < 65535) m_stat++;
      pend = fifo_rden;
      rd_word = 32'hDEAD_BEEF;
      if (fifo_rden) begin
        rd_word = src.size() != 0 ? src.pop_front() : '0;
        pend_d = rd_word;
      end
      if (e_rden) begin exp_q.push_back(rd_word); issued++; end
      if (e_pop) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        popped++;
      end
      if (m_st == 0) begin
        if (start && !abort && frame_len != 0 && frame_num != 0) begin
          m_st = 1; m_len = frame_len; total = m_len * int'(frame_num);
          issued = 0; popped = 0; exp_q.delete(); m_stat = 0;
        end
      end else if (m_st == 1) begin
        if (e_done) m_st = 0;
        else if (abort) begin m_st = 2; exp_q.delete(); end
      end else if (!m_infl) m_st = 0;
      m_infl = e_rden;
    end
  end

  task automatic xfer(input int len, input int num, input int rmode, input int st_at, input int st_len,
                      input int ab_at, input bit seq, output int start_c, output int abort_c, output int idle_c);
    int i;
    bit fired;
    i = 0; fired = 0;
    src.delete();
    for (int k = 0; k < len * num; k++) src.push_back(seq ? DW'(k) : DW'($urandom));
    log_d.delete(); log_u.delete(); log_l.delete(); log_c.delete();
    rden_cnt = 0; done_cnt = 0; done_idx = -1; cfg_cnt = 0; first_v = -1;
    frame_len = LW'(len); frame_num = 8'(num); start = 1; abort = 0; tready = 1'(rmode == 1);
    start_c = cyc + 1; abort_c = -1; idle_c = -1;
    do begin
      @(posedge clk); #1; i++;
      start = 0; abort = 0;
      tready = rmode == 1 ? 1'b1 : rmode == 3 ? 1'(i % 2) : ($urandom_range(0, 3) != 0);
      starve = st_at >= 0 ? (i >= st_at && i < st_at + st_len) : (rmode == 2 && $urandom_range(0, 4) == 0);
      if (ab_at >= 0 && !fired && log_d.size() >= ab_at) begin abort = 1; fired = 1; abort_c = cyc + 1; end
      if (rmode == 2 && busy && $urandom_range(0, 15) == 0) begin
        start = 1; frame_len = LW'($urandom_range(1, 9));
      end
    end while ((busy || i < 3) && i < 400);
    idle_c = cyc + 1;
    if (i >= 400) chk("xfer_timeout_busy", busy, 0);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    // basic 4x2 transfer with tready held high
    xfer(4, 2, 1, -1, 0, -1, 1, sc, ac, ic);
    chk("t1_latency", first_v - sc, 3);
    chk("t1_words", log_d.size(), 8);
    for (int k = 0; k < 8 && k < log_d.size(); k++) begin
      chk("t1_data", log_d[k], k); chk("t1_user", log_u[k], k % 4 == 0); chk("t1_last", log_l[k], k % 4 == 3);
    end
    if (log_c.size() == 8) chk("t1_last_cycle", log_c[7] - sc, 10);
    chk("t1_done_cnt", done_cnt, 1); chk("t1_done_idx", done_idx, 7); chk("t1_rden_cnt", rden_cnt, 8);
    // toggling tready
    xfer(4, 2, 3, -1, 0, -1, 1, sc, ac, ic);
    chk("t2_words", log_d.size(), 8);
    for (int k = 0; k < 8 && k < log_d.size(); k++) chk("t2_data", log_d[k], k);
    chk("t2_rden_cnt", rden_cnt, 8); chk("t2_done_cnt", done_cnt, 1);
    // FIFO runs dry mid-frame: 7 empty cycles, 5 of them with the pipeline drained
    xfer(4, 2, 1, 5, 7, -1, 1, sc, ac, ic);
    chk("t3_words", log_d.size(), 8);
    for (int k = 0; k < 8 && k < log_d.size(); k++) chk("t3_data", log_d[k], k);
    chk("t3_done_cnt", done_cnt, 1);
`ifdef IMG3D_CACHE_RD_STAT_EN
    chk("t3_stat", stat_underrun, 5);
`else
    chk("t3_stat", stat_underrun, 0);
`endif
    // abort after 3 pops
    xfer(8, 1, 1, -1, 0, 3, 1, sc, ac, ic);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_rden_le5", rden_cnt <= 5, 1);
    chk("t4_idle_within_2", (ic - ac) <= 2, 1);
    // zero frame length
    xfer(0, 3, 1, -1, 0, -1, 1, sc, ac, ic);
    chk("t5_cfg_cnt", cfg_cnt, 1); chk("t5_rden_cnt", rden_cnt, 0); chk("t5_busy", busy, 0);
    // single-word frames
    xfer(1, 3, 1, -1, 0, -1, 1, sc, ac, ic);
    chk("t6_words", log_d.size(), 3);
    for (int k = 0; k < 3 && k < log_d.size(); k++) begin
      chk("t6_user", log_u[k], 1); chk("t6_last", log_l[k], 1);
    end
    chk("t6_done_idx", done_idx, 2);
    // abort beats start in IDLE
    @(posedge clk); #1;
    src.delete(); frame_len = 4; frame_num = 1; start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    chk("abort_start_busy", busy, 0);
    // reset mid-transfer
    for (int k = 0; k < 16; k++) src.push_back(DW'(k));
    frame_len = 8; frame_num = 2; start = 1; tready = 1;
    repeat (6) begin @(posedge clk); #1; start = 0; end
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_mid_busy", busy, 0); chk("rst_mid_tvalid", tvalid, 0); chk("rst_mid_rden", fifo_rden, 0);
    // randomized transfers
    for (int t = 0; t < 25; t++) begin
      int l, n, ab;
      l = $urandom_range(1, 6); n = $urandom_range(1, 4);
      ab = $urandom_range(0, 3) == 0 ? $urandom_range(0, l * n) : -1;
      xfer(l, n, 2, -1, 0, ab, 0, sc, ac, ic);
      if (ab < 0) begin
        chk("rnd_words", log_d.size(), l * n); chk("rnd_done_cnt", done_cnt, 1); chk("rnd_rden_cnt", rden_cnt, l * n);
      end
    end
    starve = 0;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
